// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM for a multi-cycle RISC-V style datapath. The FSM moves each
// instruction through FETCH -> DECODE -> execute/memory states -> write-back.
// It decodes the datapath strobes combinationally from the current state, and
// for a few outputs also from mem_ready, zero and funct3.
//
// A wait counter watches every state that talks to memory (FETCH, MEMRD,
// MEMWR). If mem_ready stays low for TIMEOUT consecutive cycles, the FSM parks
// in FAULT. Only rst leaves FAULT.
//
// Parameters
//   TIMEOUT     consecutive memory-wait cycles tolerated before faulting
//               (legal range 2..255)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   opcode      IR[6:0], held from the FETCH ir_write until the next FETCH
//   funct3      IR[14:12], selects the branch condition
//   zero        ALU zero flag, valid in the same cycle
//   mem_ready   memory completes the pending access this cycle
//   mem_req     memory access request
//   mem_we      memory write access
//   iord        memory address source (0 = PC, 1 = ALUOut)
//   ir_write    instruction register load strobe
//   pc_write    program counter load strobe
//   pc_src      PC next source (0 = ALU result, 1 = ALUOut)
//   reg_write   register file write strobe
//   mem_to_reg  register write data select (1 = memory data)
//   alusrc_a    ALU A operand (0 = PC, 1 = rs1)
//   alusrc_b    ALU B operand (00 = rs2, 01 = const 4, 10 = imm)
//   aluop       ALU operation class for alu_ctrl
//   retire      one-cycle pulse per completed instruction
//   fault       sticky fault indication
//   state       current FSM state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] aluop,
  output logic       retire,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd15
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // The counter holds (wait cycles already spent). The TIMEOUT-th wait cycle
  // therefore sees a count of TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_hit;
  logic       mem_state;

  // beq takes the branch on zero, bne on !zero. Other encodings never write
  // the PC.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z);
    logic taken;
    taken = 1'b0;
    if (f3 == 3'b000) taken = z;
    else if (f3 == 3'b001) taken = ~z;
    return taken;
  endfunction

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                       (state_q == S_MEMWR);
  assign timeout_hit = ~mem_ready && (wait_q == WAIT_LAST);

  // Next state and output decode
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alusrc_a   = 1'b0;
    alusrc_b   = SRCB_RS2;
    aluop      = ALUOP_ADD;
    retire     = 1'b0;
    fault      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alusrc_b = SRCB_IMM;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEMADR;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alusrc_a = 1'b1;
        alusrc_b = SRCB_IMM;
        state_d  = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_EXEC_R: begin
        alusrc_a = 1'b1;
        alusrc_b = SRCB_RS2;
        aluop    = ALUOP_R;
        state_d  = S_ALUWB;
      end
      S_EXEC_I: begin
        alusrc_a = 1'b1;
        alusrc_b = SRCB_IMM;
        aluop    = ALUOP_I;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a = 1'b1;
        alusrc_b = SRCB_RS2;
        aluop    = ALUOP_BR;
        pc_src   = 1'b1;
        retire   = 1'b1;
        pc_write = branch_taken(funct3, zero);
        state_d  = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        // Unused encodings are unreachable. Treat them as a fault so a
        // corrupted state register cannot keep issuing strobes.
        state_d = S_FAULT;
      end
    endcase

    // Reset silences every strobe in the same cycle. An access that is in
    // flight when rst rises is therefore abandoned immediately.
    if (rst) begin
      state_d    = S_FETCH;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alusrc_a   = 1'b0;
      alusrc_b   = SRCB_RS2;
      aluop      = ALUOP_ADD;
      retire     = 1'b0;
      fault      = 1'b0;
    end
  end

  // Wait counter: a memory state only loops on itself while mem_ready is low.
  // Staying put therefore means "one more wait cycle". Any transition clears
  // the counter, and that covers entry into FETCH, MEMRD and MEMWR.
  always_comb begin
    wait_d = '0;
    if (!rst && mem_state && (state_d == state_q)) begin
      wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: number of consecutive memory-wait cycles with mem_ready low before faulting; legal range 2..255.
REQ-002 SHALL have ports clk  in  1  (system clock, rising edge) and rst  in  1  (reset).
REQ-003 SHALL use one clock; rst SHALL be synchronous and active-high.
REQ-004 SHALL have opcode  in  7  (IR[6:0], stable from the FETCH ir_write until the next FETCH).
REQ-005 SHALL have funct3  in  3  (IR[14:12]).
REQ-006 SHALL have zero  in  1  (ALU zero flag, same cycle).
REQ-007 SHALL have mem_ready  in  1  (memory completes the access this cycle).
REQ-008 SHALL have mem_req  out  1  (memory access request).
REQ-009 SHALL have mem_we  out  1  (write access).
REQ-010 SHALL have iord  out  1  (memory address source: 0=PC, 1=ALUOut).
REQ-011 SHALL have ir_write  out  1  and  pc_write  out  1  (register load strobes).
REQ-012 SHALL have pc_src  out  1  (0=ALU result, 1=ALUOut).
REQ-013 SHALL have reg_write  out  1  and  mem_to_reg  out  1  (register file write and write-data select).
REQ-014 SHALL have alusrc_a  out  1  (0=PC, 1=rs1) and alusrc_b  out  2  (00=rs2, 01=const 4, 10=imm).
REQ-015 SHALL have aluop  out  2  (00=add/load-store, 01=branch, 10=R-type, 11=I-type ALU), feeding alu_ctrl.
REQ-016 SHALL have retire  out  1  (one-cycle pulse per completed instruction), fault  out  1  (sticky), and state  out  4  (debug).

Function
REQ-017 SHALL implement the states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, FAULT=15; the state register SHALL drive the state output.
REQ-018 SHALL decode every output combinationally from the state (plus mem_ready, zero and funct3 where stated); any output not listed for a state SHALL be 0.
REQ-019 FETCH SHALL drive mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluop=00; when mem_ready=1 it SHALL also drive ir_write=1 and pc_write=1 (PC+4) and go to DECODE, otherwise it SHALL stay in FETCH.
REQ-020 DECODE SHALL drive alusrc_a=0, alusrc_b=10, aluop=00 (branch target into ALUOut) and dispatch on opcode: 0110011 to EXEC_R; 0010011 to EXEC_I; 0000011 or 0100011 to MEMADR; 1100011 to BRANCH; any other opcode to FAULT.
REQ-021 MEMADR SHALL drive alusrc_a=1, alusrc_b=10, aluop=00 and go to MEMRD if opcode=0000011, else to MEMWR.
REQ-022 MEMRD SHALL drive mem_req=1, iord=1 and go to MEMWB on mem_ready=1.
REQ-023 MEMWB SHALL drive reg_write=1, mem_to_reg=1, retire=1 and go to FETCH.
REQ-024 MEMWR SHALL drive mem_req=1, mem_we=1, iord=1; on mem_ready=1 it SHALL drive retire=1 and go to FETCH.
REQ-025 EXEC_R SHALL drive alusrc_a=1, alusrc_b=00, aluop=10; EXEC_I SHALL drive alusrc_a=1, alusrc_b=10, aluop=11; both SHALL go to ALUWB.
REQ-026 ALUWB SHALL drive reg_write=1, mem_to_reg=0, retire=1 and go to FETCH.
REQ-027 BRANCH SHALL drive alusrc_a=1, alusrc_b=00, aluop=01, pc_src=1, retire=1, and pc_write=1 iff (funct3=000 and zero=1) or (funct3=001 and zero=0); any other funct3 SHALL not write the PC; BRANCH SHALL always go to FETCH.
REQ-028 The wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and increment each cycle spent in one of those states with mem_ready=0.
REQ-029 If mem_ready=0 in the TIMEOUT-th consecutive wait cycle, the block SHALL go to FAULT; mem_ready=1 in any earlier cycle, or in that cycle, SHALL complete the access normally.
REQ-030 FAULT SHALL drive fault=1 with every strobe 0 and SHALL be left only by rst.
REQ-031 Latency SHALL be, with zero-wait memory: R/I-type 4 cycles, branch 3, store 4, load 5; each memory wait cycle SHALL add 1.

Reset
REQ-032 While rst=1, all outputs SHALL be 0 (state reads 0), the next state SHALL be FETCH and the wait counter SHALL be 0.
REQ-033 rst asserted in any state, including mid-access and FAULT, SHALL abort the instruction with no further strobes; the first cycle after rst deasserts SHALL be FETCH with mem_req=1.

Verification
REQ-034 add (opcode 0110011, zero-wait) -> states 0,1,6,8; aluop=10 in state 6; reg_write and retire each for 1 cycle in state 8.
REQ-035 lw with mem_ready delayed 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4; mem_to_reg=1 in state 4; 8 cycles total.
REQ-036 beq with zero=1 then bne with zero=1 -> pc_write=1 with pc_src=1 in the first BRANCH state, pc_write=0 in the second.
REQ-037 Illegal opcode 1111111 -> FAULT after DECODE; fault stays 1 for 20 or more cycles with every strobe 0, and clears only on rst.
REQ-038 TIMEOUT=4, mem_ready held low in FETCH -> 4 FETCH cycles, then FAULT; repeat with mem_ready=1 in the 4th cycle -> goes to DECODE.
REQ-039 rst pulsed in MEMWR while mem_ready=0 -> no mem_we after the reset cycle; the next cycle is FETCH with mem_req=1 and iord=0.
